// File: rtl/des_pkg.sv
// Shared state encoding, DES key-rotation schedule and PC2 selection used by the
// DES round controller and its key scheduler.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // SHIFT[1..16]; indices outside the schedule rotate by zero.
    function automatic logic [1:0] shift_of(input logic [4:0] idx);
        case (idx)
            5'd1, 5'd2, 5'd9, 5'd16:                  return 2'd1;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: return 2'd2;
            default:                                  return 2'd0;
        endcase
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    // Table positions count from 1 at the MSB of {C,D}.
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[47-i] = cd[56-PC2_TAB[i]];
        end
        return k;
    endfunction

endpackage

// File: rtl/des_key_sched.sv
// C/D key registers for the DES round controller: loads the first-round key
// halves, rotates them per round (left to encrypt, right to decrypt) and emits PC2.
module des_key_sched
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        mode,
    input  logic [55:0] key_in,
    input  logic [3:0]  round,
    output logic [47:0] subkey
);

    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [1:0]  amt;

    // Decrypt starts from K16's halves, which equal the unrotated key after a full 28-bit cycle.
    always_comb begin
        c_d = c_q;
        d_d = d_q;
        amt = 2'd0;
        if (load) begin
            if (mode) begin
                c_d = key_in[55:28];
                d_d = key_in[27:0];
            end else begin
                c_d = rotl28(key_in[55:28], 2'd1);
                d_d = rotl28(key_in[27:0], 2'd1);
            end
        end else if (step) begin
            if (mode) begin
                amt = shift_of(5'd16 - {1'b0, round});
                c_d = rotr28(c_q, amt);
                d_d = rotr28(d_q, amt);
            end else begin
                amt = shift_of({1'b0, round} + 5'd2);
                c_d = rotl28(c_q, amt);
                d_d = rotl28(d_q, amt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            d_q <= '0;
        end else begin
            c_q <= c_d;
            d_q <= d_d;
        end
    end

    assign subkey = pc2({c_q, d_q});

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round controller: sequences 16 Feistel rounds around an external
// f-function with 0 or 1 registered stages and hands back the pre-output block.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int F_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [63:0] block_in,
    input  logic [55:0] key_in,
    output logic [31:0] f_r,
    output logic [47:0] f_subkey,
    input  logic [31:0] f_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] block_out,
    output logic        busy,
    output logic [3:0]  round
);

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        in_ready_q, in_ready_d;
    logic        accept;
    logic        complete;
    logic        key_mode;

    // A round completes in ROUND when f is combinational, otherwise in the WAIT that follows.
    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        r_d      = r_q;
        round_d  = round_q;
        mode_d   = mode_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    l_d     = block_in[63:32];
                    r_d     = block_in[31:0];
                    mode_d  = decrypt;
                    round_d = 4'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (F_LATENCY == 0) begin
                    complete = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: complete = 1'b1;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            l_d = r_q;
            r_d = l_q ^ f_result;
            if (round_q == 4'd15) begin
                round_d = 4'd0;
                state_d = DONE;
            end else begin
                round_d = round_q + 4'd1;
                state_d = ROUND;
            end
        end

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            round_q     <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            round_q     <= round_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign key_mode = accept ? decrypt : mode_q;

    des_key_sched u_key_sched (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (complete),
        .mode   (key_mode),
        .key_in (key_in),
        .round  (round_q),
        .subkey (f_subkey)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign f_r       = r_q;
    assign block_out = {r_q, l_q};
    assign round     = round_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench: two controllers (combinational and one-stage registered f),
// checked against a textbook DES model and published known-answer vectors.
module tb_des_round_ctrl;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    logic        clk;
    logic        rst_n;
    logic        in_valid_a  [2];
    logic        decrypt_a   [2];
    logic [63:0] block_in_a  [2];
    logic [55:0] key_in_a    [2];
    logic        out_ready_a [2];
    logic        in_ready_a  [2];
    logic        out_valid_a [2];
    logic        busy_a      [2];
    logic [31:0] f_r_a       [2];
    logic [47:0] f_subkey_a  [2];
    logic [63:0] block_out_a [2];
    logic [3:0]  round_a     [2];
    logic [31:0] f_result0;
    logic [31:0] f_result1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TAB[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TAB[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b;
        int          row;
        int          col;
        e = '0;
        s = '0;
        p = '0;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TAB[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[47-6*j -: 6];
            row = 2 * int'(b[5]) + int'(b[0]);
            col = int'(b[4:1]);
            s[31-4*j -: 4] = 4'(SBOX[j][row*16+col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
        return p;
    endfunction

    // Textbook DES on the raw 64-bit key and block, subkeys reversed for decrypt.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [63:0] x;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        cd = pc1_perm(key);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SHIFTS[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = pc2_perm({c, d});
        end
        x = ip_perm(blk);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ des_f(r, ks[dec ? 15 - i : i]);
            l = t;
        end
        return fp_perm({r, l});
    endfunction

    des_round_ctrl #(.F_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .decrypt(decrypt_a[0]),
        .block_in(block_in_a[0]), .key_in(key_in_a[0]),
        .f_r(f_r_a[0]), .f_subkey(f_subkey_a[0]), .f_result(f_result0),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .block_out(block_out_a[0]), .busy(busy_a[0]), .round(round_a[0])
    );

    des_round_ctrl #(.F_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .decrypt(decrypt_a[1]),
        .block_in(block_in_a[1]), .key_in(key_in_a[1]),
        .f_r(f_r_a[1]), .f_subkey(f_subkey_a[1]), .f_result(f_result1),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .block_out(block_out_a[1]), .busy(busy_a[1]), .round(round_a[1])
    );

    always_comb f_result0 = des_f(f_r_a[0], f_subkey_a[0]);

    always_ff @(posedge clk) f_result1 <= des_f(f_r_a[1], f_subkey_a[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Latency counts the accepting edge as cycle 1 and the edge raising out_valid as cycle N.
    task automatic run_op(input int which, input logic [55:0] key, input logic [63:0] blk,
                          input logic dec, input int hold, input bit early_ready,
                          output logic [63:0] res, output logic [47:0] first_sk,
                          output int lat, output int round_err, output logic [3:0] done_round);
        int j;
        key_in_a[which]    = key;
        block_in_a[which]  = blk;
        decrypt_a[which]   = dec;
        in_valid_a[which]  = 1'b1;
        out_ready_a[which] = 1'b0;
        @(posedge clk); #1;
        in_valid_a[which]  = 1'b0;
        out_ready_a[which] = early_ready;
        first_sk  = f_subkey_a[which];
        lat       = 1;
        j         = 0;
        round_err = 0;
        while (out_valid_a[which] !== 1'b1 && lat < 100) begin
            if (round_a[which] !== 4'(j / (which + 1))) round_err++;
            decrypt_a[which]  = ~decrypt_a[which];
            block_in_a[which] = ~block_in_a[which];
            in_valid_a[which] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            j++;
        end
        in_valid_a[which] = 1'b0;
        res        = block_out_a[which];
        done_round = round_a[which];
        if (!early_ready) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready_a[which] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[which] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (out_valid_a[w] !== 1'b0) begin
                n_fail++; $display("[TB] FAIL reset_out_valid[%0d]: got %b expected 0", w, out_valid_a[w]);
            end
            n_checks++;
            if (busy_a[w] !== 1'b0) begin
                n_fail++; $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", w, busy_a[w]);
            end
            n_checks++;
            if (in_ready_a[w] !== 1'b1) begin
                n_fail++; $display("[TB] FAIL reset_in_ready[%0d]: got %b expected 1", w, in_ready_a[w]);
            end
            n_checks++;
            if (block_out_a[w] !== 64'd0) begin
                n_fail++; $display("[TB] FAIL reset_block_out[%0d]: got %h expected 0", w, block_out_a[w]);
            end
            n_checks++;
            if (f_r_a[w] !== 32'd0 || f_subkey_a[w] !== 48'd0) begin
                n_fail++; $display("[TB] FAIL reset_f_bus[%0d]: got %h/%h expected 0/0", w, f_r_a[w], f_subkey_a[w]);
            end
            n_checks++;
            if (round_a[w] !== 4'd0) begin
                n_fail++; $display("[TB] FAIL reset_round[%0d]: got %0d expected 0", w, round_a[w]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (in_ready_a[w] !== 1'b1 || busy_a[w] !== 1'b0) begin
                n_fail++; $display("[TB] FAIL post_reset_ready[%0d]: got ready=%b busy=%b expected 1/0", w, in_ready_a[w], busy_a[w]);
            end
        end
    endtask

    task automatic test_kat(input int which, input logic dec, input logic [63:0] din,
                            input logic [63:0] dexp, input logic [47:0] sk_exp, input int lat_exp);
        logic [63:0] res;
        logic [47:0] sk;
        logic [3:0]  dr;
        int          lat;
        int          rerr;
        run_op(which, pc1_perm(KAT_KEY), ip_perm(din), dec, 2, 1'b0, res, sk, lat, rerr, dr);
        n_checks++;
        if (sk !== sk_exp) begin
            n_fail++; $display("[TB] FAIL kat_first_subkey[%0d,dec=%b]: got %h expected %h", which, dec, sk, sk_exp);
        end
        n_checks++;
        if (lat !== lat_exp) begin
            n_fail++; $display("[TB] FAIL kat_latency[%0d,dec=%b]: got %0d expected %0d", which, dec, lat, lat_exp);
        end
        n_checks++;
        if (fp_perm(res) !== dexp) begin
            n_fail++; $display("[TB] FAIL kat_result[%0d,dec=%b]: got %h expected %h", which, dec, fp_perm(res), dexp);
        end
        n_checks++;
        if (rerr !== 0 || dr !== 4'd0) begin
            n_fail++; $display("[TB] FAIL kat_round_index[%0d,dec=%b]: got %0d bad cycles, done round %0d, expected 0/0", which, dec, rerr, dr);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        int          guard;
        key_in_a[0]    = pc1_perm(KAT_KEY);
        block_in_a[0]  = ip_perm(KAT_PT);
        decrypt_a[0]   = 1'b0;
        in_valid_a[0]  = 1'b1;
        out_ready_a[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        guard = 0;
        while (out_valid_a[0] !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (out_valid_a[0] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bp_done_timeout: got out_valid=%b expected 1", out_valid_a[0]);
        end
        held = block_out_a[0];
        for (int i = 0; i < 5; i++) begin
            in_valid_a[0] = i[0];
            block_in_a[0] = ~block_in_a[0];
            @(posedge clk); #1;
            n_checks++;
            if (block_out_a[0] !== held || out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL bp_hold[%0d]: got out=%h valid=%b ready=%b expected %h/1/0",
                         i, block_out_a[0], out_valid_a[0], in_ready_a[0], held);
            end
        end
        n_checks++;
        if (fp_perm(held) !== KAT_CT) begin
            n_fail++; $display("[TB] FAIL bp_result: got %h expected %h", fp_perm(held), KAT_CT);
        end
        in_valid_a[0]  = 1'b1;
        out_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b0;
        n_checks++;
        if (in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || out_valid_a[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_release: got ready=%b busy=%b valid=%b expected 1/0/0",
                     in_ready_a[0], busy_a[0], out_valid_a[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        logic [47:0] sk;
        logic [3:0]  dr;
        int          lat;
        int          rerr;
        int          guard;
        key_in_a[0]   = pc1_perm(KAT_KEY);
        block_in_a[0] = ip_perm(KAT_PT);
        decrypt_a[0]  = 1'b1;
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        guard = 0;
        while (round_a[0] !== 4'd7 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (round_a[0] !== 4'd7) begin
            n_fail++; $display("[TB] FAIL mid_reach_round7: got %0d expected 7", round_a[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_a[0], in_ready_a[0], out_valid_a[0], round_a[0]} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_ctrl: got busy=%b ready=%b valid=%b round=%0d expected 0/1/0/0",
                     busy_a[0], in_ready_a[0], out_valid_a[0], round_a[0]);
        end
        n_checks++;
        if ({block_out_a[0], f_r_a[0], f_subkey_a[0]} !== 144'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_data: got %h %h %h expected zeros", block_out_a[0], f_r_a[0], f_subkey_a[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_no_partial: got valid=%b busy=%b expected 0/0", out_valid_a[0], busy_a[0]);
        end
        run_op(0, pc1_perm(KAT_KEY), ip_perm(KAT_PT), 1'b0, 0, 1'b0, res, sk, lat, rerr, dr);
        n_checks++;
        if (fp_perm(res) !== KAT_CT || lat !== 17) begin
            n_fail++; $display("[TB] FAIL mid_rerun: got %h lat %0d expected %h lat 17", fp_perm(res), lat, KAT_CT);
        end
    endtask

    // Random and all-zero/all-one operands on both latencies, plus an encrypt/decrypt round trip.
    task automatic test_random();
        logic [63:0] key;
        logic [63:0] din;
        logic [63:0] exp_out;
        logic [63:0] res;
        logic [63:0] back;
        logic [47:0] sk;
        logic [3:0]  dr;
        logic        dec;
        int          which;
        int          lat;
        int          rerr;
        for (int n = 0; n < 12; n++) begin
            which = n % 2;
            case (n)
                0:       begin key = '0; din = '0; end
                1:       begin key = '1; din = '1; end
                2:       begin key = '0; din = '1; end
                3:       begin key = '1; din = '0; end
                default: begin key = {$urandom, $urandom}; din = {$urandom, $urandom}; end
            endcase
            dec     = 1'($urandom_range(0, 1));
            exp_out = des_ref(key, din, dec);
            run_op(which, pc1_perm(key), ip_perm(din), dec, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), res, sk, lat, rerr, dr);
            n_checks++;
            if (fp_perm(res) !== exp_out) begin
                n_fail++; $display("[TB] FAIL rand_result[%0d]: got %h expected %h", n, fp_perm(res), exp_out);
            end
            n_checks++;
            if (lat !== (which == 1 ? 33 : 17) || rerr !== 0) begin
                n_fail++; $display("[TB] FAIL rand_timing[%0d]: got lat %0d bad rounds %0d expected %0d/0",
                                   n, lat, rerr, (which == 1 ? 33 : 17));
            end
            run_op(which, pc1_perm(key), res, ~dec, 0, 1'b0, back, sk, lat, rerr, dr);
            n_checks++;
            if (fp_perm(back) !== din) begin
                n_fail++; $display("[TB] FAIL rand_roundtrip[%0d]: got %h expected %h", n, fp_perm(back), din);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid_a[w]  = 1'b0;
            decrypt_a[w]   = 1'b0;
            block_in_a[w]  = '0;
            key_in_a[w]    = '0;
            out_ready_a[w] = 1'b0;
        end
        test_reset();
        test_kat(0, 1'b0, KAT_PT, KAT_CT, 48'h1B02EFFC7072, 17);
        test_kat(0, 1'b1, KAT_CT, KAT_PT, 48'hCB3D8B0E17F5, 17);
        test_backpressure();
        test_reset_mid();
        test_kat(1, 1'b0, KAT_PT, KAT_CT, 48'h1B02EFFC7072, 33);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_round_ctrl.md
DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 SHALL have parameter F_LATENCY, default 0, giving the registered pipeline stages in the external f-function; legal values are 0 and 1.
REQ-002 SHALL have one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock for all state.
REQ-003 SHALL have rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have in_valid input 1, new block and key offered.
REQ-005 SHALL have in_ready output 1, controller can accept; equals (state==IDLE).
REQ-006 SHALL have decrypt input 1, mode (1 = decrypt), sampled only at accept.
REQ-007 SHALL have block_in input 64, post-IP block {L0,R0}.
REQ-008 SHALL have key_in input 56, post-PC1 key {C0,D0}.
REQ-009 SHALL have f_r output 32, current R sent to the external f-function built from s1..s8.
REQ-010 SHALL have f_subkey output 48, PC2 of the current {C,D} registers.
REQ-011 SHALL have f_result input 32, f(f_r, f_subkey) returned after F_LATENCY cycles.
REQ-012 SHALL have out_valid output 1, result available.
REQ-013 SHALL have out_ready input 1, consumer accepts result.
REQ-014 SHALL have block_out output 64, pre-output {R16,L16} (FP applied externally).
REQ-015 SHALL have busy output 1, high in any state except IDLE.
REQ-016 SHALL have round output 4, index of the round in progress, 0..15.

Function
REQ-017 SHALL implement FSM states IDLE, ROUND, WAIT, DONE; WAIT is used only when F_LATENCY=1.
REQ-018 SHALL, in IDLE on in_valid&&in_ready, capture L,R from block_in, capture mode, load round=0, and go to ROUND.
REQ-019 SHALL, for encrypt, load {C,D}=rotl28 of each half by 1 at accept; after each round, rotate left by SHIFT[next round].
REQ-020 SHALL, for decrypt, load {C,D}=key_in unrotated (K16); after round i, rotate right by SHIFT[17-i].
REQ-021 SHALL use SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-022 SHALL, on each round completion, update L<=R and R<=L^f_result, and advance the key rotation.
REQ-023 SHALL complete rounds in ROUND (F_LATENCY=0) or in WAIT (F_LATENCY=1); ROUND goes to WAIT, WAIT goes to ROUND.
REQ-024 SHALL hold f_r and f_subkey stable across each ROUND/WAIT pair.
REQ-025 SHALL, on completion of round 15, go to DONE with out_valid=1 and block_out={R,L}, and reset round to 0.
REQ-026 SHALL give a latency from the accepting edge to first out_valid high of 17 cycles (F_LATENCY=0) or 33 cycles (F_LATENCY=1).
REQ-027 SHALL hold block_out and out_valid stable in DONE until out_ready=1; out_ready while not DONE is ignored.
REQ-028 SHALL leave DONE for IDLE on out_valid&&out_ready; in_ready rises the following cycle with no same-cycle bypass.
REQ-029 SHALL ignore in_valid while busy, and SHALL leave mode unchanged on later decrypt toggles.
REQ-030 SHALL treat all-zero and all-one keys and blocks as ordinary operands, with no special casing.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-round, force state=IDLE, L=R=C=D=0, round=0, and mode=0.
REQ-032 SHALL give reset output values out_valid=0, busy=0, in_ready=1, block_out=0, f_r=0, f_subkey=0, round=0.
REQ-033 SHALL discard any aborted operation and SHALL NOT produce a partial result.

Structure
REQ-034 SHALL place the SHIFT table, the PC2 function, and the state enum in package des_pkg.
REQ-035 SHALL use one sub-module, des_key_sched, which holds C/D, performs the left/right rotation and PC2, and is driven by load/step/mode.
REQ-036 SHALL keep the f-function (E, key XOR, s1..s8, P) outside this block.

Verification
REQ-037 SHALL check reset: rst_n low for 3 cycles -> all outputs at REQ-032 values; in_ready=1 after release.
REQ-038 SHALL check encrypt, F_LATENCY=0: bench-side IP/PC1 of key 133457799BBCDFF1 and plaintext 0123456789ABCDEF -> f_subkey=1B02EFFC7072 in the first ROUND cycle; out_valid 17 cycles after accept; FP(block_out)=85E813540F0AB405.
REQ-039 SHALL check decrypt: same key, ciphertext 85E813540F0AB405 -> first f_subkey=CB3D8B0E17F5; FP(block_out)=0123456789ABCDEF.
REQ-040 SHALL check backpressure: out_ready low for 5 cycles in DONE, with in_valid pulsed -> block_out stable, in_ready=0, no second capture; accept on out_ready -> in_ready=1 the next cycle.
REQ-041 SHALL check reset mid-operation: rst_n pulsed while round=7 -> immediate IDLE and zeroed outputs; the following encrypt of the REQ-038 vector is still correct.
REQ-042 SHALL check F_LATENCY=1 with a one-stage registered f-function: the REQ-038 vector gives out_valid 33 cycles after accept with the same result.
